// File: rtl/hwag_cap_pkg.sv
// Shared types and default widths for the multi-channel VR capture block.
package hwag_cap_pkg;

    typedef enum logic [1:0] {
        EM_NONE = 2'b00,
        EM_RISE = 2'b01,
        EM_FALL = 2'b10,
        EM_BOTH = 2'b11
    } edge_mode_t;

    localparam int CH_DEF    = 4;
    localparam int FLT_W_DEF = 16;
    localparam int TS_W_DEF  = 24;

    function automatic logic mode_rise(input edge_mode_t m);
        return (m == EM_RISE) || (m == EM_BOTH);
    endfunction

    function automatic logic mode_fall(input edge_mode_t m);
        return (m == EM_FALL) || (m == EM_BOTH);
    endfunction

endpackage

// File: rtl/hwag_cap_channel.sv
// One capture channel: 2-flop synchroniser, glitch filter, edge detector and
// timestamp capture with pending/overflow tracking.
module hwag_cap_channel
    import hwag_cap_pkg::*;
#(
    parameter int FLT_W = FLT_W_DEF,
    parameter int TS_W  = TS_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vr_in,
    input  logic             flt_ena,
    input  logic [FLT_W-1:0] flt_val,
    input  logic [1:0]       edge_mode,
    input  logic             cap_ena,
    input  logic             ack,
    input  logic [TS_W-1:0]  timer,
    output logic             filtered,
    output logic             edge_rise,
    output logic             edge_fall,
    output logic [TS_W-1:0]  cap_ts,
    output logic             cap_pend,
    output logic             cap_ovf
);

    logic             s1, s2;
    logic             filt_d;
    logic [FLT_W-1:0] cnt;
    logic             evt;
    edge_mode_t       mode;

    assign mode = edge_mode_t'(edge_mode);
    assign evt  = edge_rise | edge_fall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= vr_in;
            s2 <= s1;
        end
    end

    // cnt only increments while below flt_val, so it can never wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filtered <= 1'b0;
            cnt      <= '0;
        end else if (!flt_ena) begin
            filtered <= s2;
            cnt      <= '0;
        end else if (s2 == filtered) begin
            cnt      <= '0;
        end else if (cnt >= flt_val) begin
            filtered <= s2;
            cnt      <= '0;
        end else begin
            cnt      <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_d    <= 1'b0;
            edge_rise <= 1'b0;
            edge_fall <= 1'b0;
        end else begin
            filt_d    <= filtered;
            edge_rise <= cap_ena & mode_rise(mode) &  filtered & ~filt_d;
            edge_fall <= cap_ena & mode_fall(mode) & ~filtered &  filt_d;
        end
    end

    // A new event always wins over a same-cycle ack; the ack only clears overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_ts   <= '0;
            cap_pend <= 1'b0;
            cap_ovf  <= 1'b0;
        end else if (evt) begin
            cap_ts   <= timer;
            cap_pend <= 1'b1;
            if (ack)
                cap_ovf <= 1'b0;
            else if (cap_pend)
                cap_ovf <= 1'b1;
        end else if (ack) begin
            cap_pend <= 1'b0;
            cap_ovf  <= 1'b0;
        end
    end

endmodule

// File: rtl/hwag_capture_mc.sv
// Multi-channel VR capture: shared free-running timer plus CH independent
// filter/edge/capture channels fed from flat configuration buses.
module hwag_capture_mc
    import hwag_cap_pkg::*;
#(
    parameter int CH    = CH_DEF,
    parameter int FLT_W = FLT_W_DEF,
    parameter int TS_W  = TS_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       vr_in,
    input  logic [CH-1:0]       flt_ena,
    input  logic [CH*FLT_W-1:0] flt_val,
    input  logic [2*CH-1:0]     edge_mode,
    input  logic [CH-1:0]       cap_ena,
    input  logic [CH-1:0]       ack,
    output logic [CH-1:0]       filtered,
    output logic [CH-1:0]       edge_rise,
    output logic [CH-1:0]       edge_fall,
    output logic [CH*TS_W-1:0]  cap_ts,
    output logic [CH-1:0]       cap_pend,
    output logic [CH-1:0]       cap_ovf,
    output logic [TS_W-1:0]     timer
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            timer <= '0;
        else
            timer <= timer + 1'b1;
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        hwag_cap_channel #(
            .FLT_W (FLT_W),
            .TS_W  (TS_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .vr_in     (vr_in[i]),
            .flt_ena   (flt_ena[i]),
            .flt_val   (flt_val[i*FLT_W +: FLT_W]),
            .edge_mode (edge_mode[2*i +: 2]),
            .cap_ena   (cap_ena[i]),
            .ack       (ack[i]),
            .timer     (timer),
            .filtered  (filtered[i]),
            .edge_rise (edge_rise[i]),
            .edge_fall (edge_fall[i]),
            .cap_ts    (cap_ts[i*TS_W +: TS_W]),
            .cap_pend  (cap_pend[i]),
            .cap_ovf   (cap_ovf[i])
        );
    end

endmodule

// File: tb/tb_hwag_capture_mc.sv
// Scoreboard bench for hwag_capture_mc; built with an 8-bit timer so the
// wrap case is reachable in a few hundred cycles.
module tb_hwag_capture_mc;

    localparam int CH    = 4;
    localparam int FLT_W = 16;
    localparam int TS_W  = 8;
    localparam int TMASK = (1 << TS_W) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [CH-1:0]       vr_in;
    logic [CH-1:0]       flt_ena;
    logic [CH*FLT_W-1:0] flt_val;
    logic [2*CH-1:0]     edge_mode;
    logic [CH-1:0]       cap_ena;
    logic [CH-1:0]       ack;
    logic [CH-1:0]       filtered;
    logic [CH-1:0]       edge_rise;
    logic [CH-1:0]       edge_fall;
    logic [CH*TS_W-1:0]  cap_ts;
    logic [CH-1:0]       cap_pend;
    logic [CH-1:0]       cap_ovf;
    logic [TS_W-1:0]     timer;

    hwag_capture_mc #(.CH(CH), .FLT_W(FLT_W), .TS_W(TS_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .vr_in     (vr_in),
        .flt_ena   (flt_ena),
        .flt_val   (flt_val),
        .edge_mode (edge_mode),
        .cap_ena   (cap_ena),
        .ack       (ack),
        .filtered  (filtered),
        .edge_rise (edge_rise),
        .edge_fall (edge_fall),
        .cap_ts    (cap_ts),
        .cap_pend  (cap_pend),
        .cap_ovf   (cap_ovf),
        .timer     (timer)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   ch;
        logic rise;
        int   ts;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_run  = 0;
    int   n_fail = 0;
    int   cyc;

    // Reference cycle count since reset release; mirrors the expected timer.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_edge(input int c, input logic r, input int lat);
        exp_t x;
        x.ch   = c;
        x.rise = r;
        x.ts   = (cyc + lat) & TMASK;
        sb.push_back(x);
    endtask

    function automatic logic [TS_W-1:0] ts_of(input int c);
        return cap_ts[c*TS_W +: TS_W];
    endfunction

    // Every observed pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                if (edge_rise[c] | edge_fall[c]) begin
                    if (sb.size() == 0) begin
                        chk("unexp_edge", c, 64'hFFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("edge_ch", c, e.ch);
                        chk("edge_dir", edge_rise[c], e.rise);
                        chk("edge_ts", timer, e.ts);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        logic [CH-1:0] lvl;
        rst = 1'b0; vr_in = '0; flt_ena = '0; flt_val = '0;
        edge_mode = '0; cap_ena = '0; ack = '0;
        tick(3);
        rst = 1'b1;

        // Idle after reset
        tick(100);
        chk("idle_timer", timer, 100);
        chk("idle_filt", filtered, 0);
        chk("idle_pend", cap_pend, 0);
        chk("idle_ovf", cap_ovf, 0);
        chk("idle_ts", cap_ts, 0);

        // Filtered channel: short pulse rejected, long level accepted after 9 cycles
        flt_ena[0] = 1'b1; flt_val[0*FLT_W +: FLT_W] = 16'd5;
        edge_mode[1:0] = 2'b01; cap_ena[0] = 1'b1;
        vr_in[0] = 1'b1; tick(4); vr_in[0] = 1'b0;
        tick(20);
        chk("glitch_filt", filtered[0], 0);
        chk("glitch_pend", cap_pend[0], 0);
        n = cyc;
        vr_in[0] = 1'b1; expect_edge(0, 1'b1, 9);
        tick(9);
        chk("flt_rise_pulse", edge_rise[0], 1);
        tick(1);
        chk("flt_ts", ts_of(0), (n + 9) & TMASK);
        chk("flt_pend", cap_pend[0], 1);
        chk("flt_level", filtered[0], 1);

        // Unfiltered both-edge channel: overwrite sets overflow, ack clears
        edge_mode[3:2] = 2'b11; cap_ena[1] = 1'b1;
        n = cyc;
        vr_in[1] = 1'b1; expect_edge(1, 1'b1, 4);
        tick(10);
        chk("ch1_pend1", cap_pend[1], 1);
        chk("ch1_ovf1", cap_ovf[1], 0);
        chk("ch1_ts1", ts_of(1), (n + 4) & TMASK);
        vr_in[1] = 1'b0; expect_edge(1, 1'b0, 4);
        tick(10);
        chk("ch1_ovf2", cap_ovf[1], 1);
        chk("ch1_ts2", ts_of(1), (n + 14) & TMASK);
        ack[1] = 1'b1; tick(1); ack[1] = 1'b0;
        chk("ch1_ack_pend", cap_pend[1], 0);
        chk("ch1_ack_ovf", cap_ovf[1], 0);
        chk("ch1_ack_ts", ts_of(1), (n + 14) & TMASK);

        // Event coinciding with ack: event wins, overflow cleared
        edge_mode[5:4] = 2'b11; cap_ena[2] = 1'b1;
        vr_in[2] = 1'b1; expect_edge(2, 1'b1, 4); tick(10);
        vr_in[2] = 1'b0; expect_edge(2, 1'b0, 4); tick(10);
        chk("ch2_ovf_pre", cap_ovf[2], 1);
        n = cyc;
        vr_in[2] = 1'b1; expect_edge(2, 1'b1, 4);
        tick(4);
        ack[2] = 1'b1; tick(1); ack[2] = 1'b0;
        chk("ch2_pend", cap_pend[2], 1);
        chk("ch2_ovf", cap_ovf[2], 0);
        chk("ch2_ts", ts_of(2), (n + 4) & TMASK);

        // All channels toggle together
        flt_ena = '0; edge_mode = '1; cap_ena = '1;
        tick(2);
        n = cyc;
        lvl = ~vr_in;
        vr_in = lvl;
        for (int c = 0; c < CH; c++) expect_edge(c, lvl[c], 4);
        tick(5);
        for (int c = 0; c < CH; c++) chk($sformatf("all_ts%0d", c), ts_of(c), (n + 4) & TMASK);
        chk("all_pend", cap_pend, 4'b1111);
        chk("all_ovf", cap_ovf, 4'b0101);

        // Reset during a filter count
        flt_ena[0] = 1'b1; flt_val[0*FLT_W +: FLT_W] = 16'd20;
        vr_in[0] = ~vr_in[0];
        tick(6);
        chk("sb_pre_rst", sb.size(), 0);
        rst = 1'b0;
        #1;
        chk("rst_timer", timer, 0);
        chk("rst_filt", filtered, 0);
        chk("rst_rise", edge_rise, 0);
        chk("rst_fall", edge_fall, 0);
        chk("rst_pend", cap_pend, 0);
        chk("rst_ovf", cap_ovf, 0);
        chk("rst_ts", cap_ts, 0);
        vr_in = '0; flt_ena = '0; flt_val = '0; edge_mode = '0; cap_ena = '0;
        tick(3);
        rst = 1'b1;

        // Timer wrap, then capture disabled / mode none
        edge_mode[7:6] = 2'b11; cap_ena[3] = 1'b1;
        edge_mode[3:2] = 2'b00; cap_ena[1] = 1'b1;
        tick(251 - cyc);
        vr_in[3] = 1'b1; expect_edge(3, 1'b1, 4);
        tick(4);
        vr_in[3] = 1'b0; expect_edge(3, 1'b0, 4);
        tick(1);
        chk("wrap_ts255", ts_of(3), 255);
        tick(4);
        chk("wrap_ts3", ts_of(3), 3);
        chk("wrap_ovf", cap_ovf[3], 1);
        cap_ena[3] = 1'b0;
        vr_in[3] = 1'b1; vr_in[1] = 1'b1;
        tick(10);
        chk("dis_ts", ts_of(3), 3);
        chk("dis_pend", cap_pend[3], 1);
        chk("dis_filt", filtered[3], 1);
        chk("none_pend", cap_pend[1], 0);
        chk("none_filt", filtered[1], 1);
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
